// File: rtl/burst_pkg.sv
// burst_pkg: constants shared by the burst address controller and the
// burst-length comparator that sits next to it at the burst-test top.
//   - FSM state encodings (IDLE / ACCESS / DONE)
//   - default widths, which must agree between burst_ctrl and the comparator
package burst_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_COUNTER_WIDTH  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/burst_addr_counter.sv
// burst_addr_counter: loadable MRAM address and completed-beat counter.
//   clk, rst : clock, asynchronous active-high reset (both registers -> 0)
//   load     : copy base into addr and clear counter (burst start)
//   beat     : one beat accepted; addr+1 (wraps mod 2^ADDR_WIDTH), counter+1
//   base     : first address of the burst
//   addr     : current MRAM address
//   counter  : completed-beat count
// load has priority over beat; the controller never raises both together.
module burst_addr_counter
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     beat,
  input  logic [ADDR_WIDTH-1:0]    base,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [COUNTER_WIDTH-1:0] counter
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      counter <= '0;
    end else if (load) begin
      addr    <= base;
      counter <= '0;
    end else if (beat) begin
      addr    <= addr + ADDR_WIDTH'(1);
      counter <= counter + COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/burst_ctrl.sv
// burst_ctrl: burst address controller for the MRAM burst test path.
// Walks addresses from base_addr, one access per beat, and keeps the beat
// counter that feeds the external burst-length comparator; the comparator's
// combinational stop_signal ends the burst.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : burst request, sampled only in IDLE
//   wr_mode      : 1 = write burst, 0 = read burst (latched with start)
//   base_addr    : first burst address (latched with start)
//   abort        : cancel the burst in ACCESS, no done pulse
//   stop_signal  : from comparator, high when counter == burst_len
//   counter      : completed-beat count, to comparator
//   addr         : current MRAM address
//   mem_en       : access request for the current beat
//   mem_we       : write strobe (mem_en & latched wr_mode)
//   mem_ready    : MRAM accepts/completes the current beat
//   busy         : high in ACCESS
//   done         : one-cycle pulse at burst end
//   err          : timeout flag
//   state        : FSM state (debug observation)
//
// MRAM handshake: mem_en is the request and mem_ready the acceptance. A beat
// completes on a clock edge where mem_en=1 and mem_ready=1 (and abort=0);
// while mem_ready=0 the request, addr and counter are held unchanged.
//
// Build option BURST_TIMEOUT_EN: adds a per-beat wait counter; after
// TIMEOUT_CYCLES stalled request cycles err is set and the burst ends through
// DONE. Without it err is tied to 0 and the controller waits indefinitely.
module burst_ctrl
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     wr_mode,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     abort,
  input  logic                     stop_signal,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     mem_en,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               state
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       wr_q;
  logic       load;
  logic       beat;
  logic       timeout_hit;

  // The comparator is combinational, so the request drops in the same cycle
  // the count reaches burst_len: no access is issued past the last beat.
  assign mem_en = (state_q == ACCESS) & ~stop_signal;
  assign mem_we = mem_en & wr_q;
  assign busy   = (state_q == ACCESS);
  assign done   = (state_q == DONE);
  assign state  = state_q;

  // Priority in ACCESS: abort > stop > mem_ready beat > timeout.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (abort) begin
          state_d = IDLE;
        end else if (stop_signal) begin
          state_d = DONE;
        end else if (mem_ready) begin
          beat = 1'b1;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        wr_q <= wr_mode;
      end
    end
  end

  burst_addr_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_addr_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .beat   (beat),
    .base   (base_addr),
    .addr   (addr),
    .counter(counter)
  );

`ifdef BURST_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled request cycle, so the
  // edge closing that cycle sets err and moves to DONE.
  assign timeout_hit = mem_en & ~mem_ready &
                       (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (load || mem_ready) begin
        wait_q <= '0;
      end else if (mem_en) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      if (load) begin
        err_q <= 1'b0;
      end else if (busy && !abort && timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule
